rom_arbiter: RTL
================

// Module: rom_arbiter
// PURPOSE
//   Shares the single read port and the write port of the program ROM between two requesters.
//   M0 is CPU instruction fetch and is read-only. M1 is the debug/boot loader and can read and write.
//   Round-robin arbitration on read contention; a LOAD mode locks M0 out while M1 reprograms the ROM.
//   Sits between the core/loader and the ROM instance; all ROM port signals come from here.
// PARAMETERS
//   DW     32  data width of ROM words and of requester data
//   AW     7   ROM address width; requester addresses are AW bits, no truncation inside
//   CNT_W  16  width of the saturating contention counter
// PORTS
//   clk            in   1    system clock, all state on posedge
//   rst            in   1    asynchronous, active-low reset
//   m0_req         in   1    M0 read request, held until granted
//   m0_addr        in   AW   M0 read address
//   m0_gnt         out  1    M0 request accepted this cycle (combinational)
//   m0_rvalid      out  1    M0 read data valid
//   m0_rdata       out  DW   M0 read data
//   m1_req         in   1    M1 request, held until granted
//   m1_we          in   1    1 = write, 0 = read (qualified by m1_req)
//   m1_addr        in   AW   M1 address
//   m1_wdata       in   DW   M1 write data
//   m1_gnt         out  1    M1 request accepted this cycle (combinational)
//   m1_rvalid      out  1    M1 read data valid
//   m1_rdata       out  DW   M1 read data
//   load_start     in   1    pulse: enter LOAD mode
//   load_done      in   1    pulse: leave LOAD mode
//   load_mode      out  1    1 while in LOAD state
//   rom_wen        out  1    ROM write enable
//   rom_w_addr     out  AW   ROM write address
//   rom_w_data     out  DW   ROM write data
//   rom_ren        out  1    ROM read enable
//   rom_r_addr     out  AW   ROM read address
//   rom_r_data     in   DW   ROM read data, valid 1 cycle after rom_ren
//   contention_cnt out  CNT_W  count of cycles with both read requests live, saturating
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - FSM=RUN; rr_ptr=0 (M0 favoured first).
//     - rvalid/rdata of both masters = 0; contention_cnt = 0; in-flight response tag cleared.
//     - All gnt, rom_wen and rom_ren forced 0 while rst=0.
//   FSM (mode):
//     - RUN -> LOAD on load_start.
//     - LOAD -> RUN on load_done.
//     - load_start and load_done in the same cycle: stay in the current state.
//     - In LOAD, m0_gnt = 0 and M0 requests wait (no drop).
//   Writes: M1 write (m1_req & m1_we) is granted in the same cycle in either state.
//     - rom_wen=1, rom_w_addr=m1_addr, rom_w_data=m1_wdata; no read response.
//   Reads: at most one read is granted per cycle.
//     - Only one eligible read request: granted.
//     - Both eligible: the master selected by rr_ptr wins; rr_ptr then points to the loser.
//       rr_ptr changes only on contention grants.
//     - Granted read drives rom_ren=1, rom_r_addr=addr.
//     - A registered 1-bit tag records the winner.
//     - Next cycle the winner's rvalid=1 and rdata=rom_r_data for exactly 1 cycle; the other master's rvalid=0.
//     - rdata holds its last value when rvalid=0.
//   RAW hazard: a read and an M1 write to the same address in the same cycle.
//     - The read is not granted that cycle (gnt=0), so it retries and returns the new data.
//     - The write still proceeds; this cycle does not update rr_ptr.
//   Fully pipelined: a new read may be granted every cycle; read latency is fixed at 1 cycle from gnt.
//   contention_cnt increments on each cycle with both read requests eligible and holds at 2^CNT_W-1.
//     - Under the RAW hazard, the hazarded read still counts as eligible for contention_cnt.
//   Reset asserted mid-read: the pending response is discarded; no rvalid after reset release.
// TESTING
//   1) Reset release, m0_req addr 0x05 -> m0_gnt same cycle; next cycle m0_rvalid=1 with ROM[5].
//   2) M1 write 0x7F=0xDEADBEEF, then M1 read 0x7F -> m1_rdata=0xDEADBEEF one cycle after gnt.
//   3) Both read every cycle for 4 cycles -> grants M0,M1,M0,M1; contention_cnt=4.
//   4) Same cycle: M1 write 0x10=0x1234 and M0 read 0x10 -> m0_gnt=0 that cycle; next cycle granted, returns 0x1234.
//   5) load_start, M0 req held 3 cycles, load_done -> m0_gnt=0 throughout LOAD; granted first RUN cycle.
//   6) Pull rst low the cycle after a grant -> no rvalid ever returned; outputs 0; contention_cnt=0.

Source files
------------

// File: rtl/rom_arbiter.sv
// Arbitrates the program ROM read/write ports between instruction fetch (M0, read-only)
// and the debug/boot loader (M1, read/write), with a LOAD mode that locks M0 out.
module rom_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic [AW-1:0]    m0_addr,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [DW-1:0]    m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [DW-1:0]    m1_rdata,
  input  logic             load_start,
  input  logic             load_done,
  output logic             load_mode,
  output logic             rom_wen,
  output logic [AW-1:0]    rom_w_addr,
  output logic [DW-1:0]    rom_w_data,
  output logic             rom_ren,
  output logic [AW-1:0]    rom_r_addr,
  input  logic [DW-1:0]    rom_r_data,
  output logic [CNT_W-1:0] contention_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;     // 0: M0 wins next contention, 1: M1 wins
  logic             r_pend_vld;
  logic             r_pend_tag;   // 0: response belongs to M0, 1: to M1
  logic [DW-1:0]    r_m0_rdata;
  logic [DW-1:0]    r_m1_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic w_wr;
  logic w_m0_live;
  logic w_m1_live;
  logic w_m0_raw;
  logic w_m0_cand;
  logic w_m1_cand;
  logic w_both;
  logic w_m0_rd_gnt;
  logic w_m1_rd_gnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (load_start && !load_done) w_state_nxt = ST_LOAD;
      ST_LOAD: if (load_done && !load_start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Everything that can reach the ROM or a grant is qualified by rst so that
  // nothing leaks out while reset is held.
  assign w_wr      = rst & m1_req & m1_we;
  assign w_m0_live = rst & m0_req & (r_state == ST_RUN);
  assign w_m1_live = rst & m1_req & ~m1_we;

  // A read colliding with a same-cycle write is held back so it returns new data.
  assign w_m0_raw  = w_m0_live & w_wr & (m0_addr == m1_addr);
  assign w_m0_cand = w_m0_live & ~w_m0_raw;
  assign w_m1_cand = w_m1_live;
  assign w_both    = w_m0_cand & w_m1_cand;

  assign w_m0_rd_gnt = w_m0_cand & (~w_m1_cand | ~r_rr_ptr);
  assign w_m1_rd_gnt = w_m1_cand & (~w_m0_cand |  r_rr_ptr);

  assign m0_gnt     = w_m0_rd_gnt;
  assign m1_gnt     = w_wr | w_m1_rd_gnt;
  assign rom_wen    = w_wr;
  assign rom_w_addr = m1_addr;
  assign rom_w_data = m1_wdata;
  assign rom_ren    = w_m0_rd_gnt | w_m1_rd_gnt;
  assign rom_r_addr = w_m1_rd_gnt ? m1_addr : m0_addr;

  assign load_mode      = (r_state == ST_LOAD);
  assign contention_cnt = r_cnt;

  // ROM data is only present during the response cycle; the registers keep it afterwards.
  assign m0_rvalid = r_pend_vld & ~r_pend_tag;
  assign m1_rvalid = r_pend_vld &  r_pend_tag;
  assign m0_rdata  = m0_rvalid ? rom_r_data : r_m0_rdata;
  assign m1_rdata  = m1_rvalid ? rom_r_data : r_m1_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_rr_ptr   <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_tag <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_vld <= w_m0_rd_gnt | w_m1_rd_gnt;
      r_pend_tag <= w_m1_rd_gnt;
      if (w_both)
        r_rr_ptr <= ~r_rr_ptr;
      if (m0_rvalid)
        r_m0_rdata <= rom_r_data;
      if (m1_rvalid)
        r_m1_rdata <= rom_r_data;
      if (w_m0_live && w_m1_live && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
